// File: rtl/traffic_light_if.sv
// Lamp/countdown bundle for traffic_light_ctrl; master is the controller side,
// slave is the road-side environment that raises crossing requests.
interface traffic_light_if #(
  parameter int unsigned NUM_PHASES = 2,
  parameter int unsigned CNT_W      = 8
);
  localparam int unsigned PhW = ($clog2(NUM_PHASES) > 1) ? $clog2(NUM_PHASES) : 1;

  logic [NUM_PHASES-1:0] pass_request;
  logic [CNT_W-1:0]      clock;
  logic [PhW-1:0]        phase;
  logic [NUM_PHASES-1:0] red;
  logic [NUM_PHASES-1:0] yellow;
  logic [NUM_PHASES-1:0] green;

  modport master (
    input  pass_request,
    output clock,
    output phase,
    output red,
    output yellow,
    output green
  );

  modport slave (
    output pass_request,
    input  clock,
    input  phase,
    input  red,
    input  yellow,
    input  green
  );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Multi-phase traffic light sequencer: GREEN -> YELLOW -> ALLRED per phase, with
// request-driven green shortening. Define TL_DEMAND_SKIP_EN for demand-based phase skipping.
module traffic_light_ctrl #(
  parameter int unsigned NUM_PHASES = 2,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned GREEN_T    = 60,
  parameter int unsigned YELLOW_T   = 5,
  parameter int unsigned ALLRED_T   = 2,
  parameter int unsigned PASS_T     = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  traffic_light_if.master tl
);
  localparam int unsigned PhW = ($clog2(NUM_PHASES) > 1) ? $clog2(NUM_PHASES) : 1;

  typedef enum logic [1:0] {StIdle, StGreen, StYellow, StAllRed} state_e;

  state_e                state_q, state_d;
  logic [PhW-1:0]        phase_q, phase_d, next_phase;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_PHASES-1:0] red_q, red_d;
  logic [NUM_PHASES-1:0] yellow_q, yellow_d;
  logic [NUM_PHASES-1:0] green_q, green_d;
  logic                  other_req;
  logic                  cnt_last;

  assign cnt_last = (cnt_q == CNT_W'(1));

  // Only requests from phases that are currently held at red may cut the green short.
  always_comb begin
    other_req = 1'b0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (tl.pass_request[i] && (PhW'(i) != phase_q)) begin
        other_req = 1'b1;
      end
    end
  end

`ifdef TL_DEMAND_SKIP_EN
  logic [NUM_PHASES-1:0] pending_q, pending_d;
  int unsigned           cur_ph;
  int unsigned           dist;
  int unsigned           best;

  // Nearest pending phase going round from phase+1; the current phase is the last resort.
  always_comb begin
    next_phase = phase_q;
    cur_ph     = 32'(phase_q);
    dist       = 0;
    best       = NUM_PHASES + 1;
    for (int unsigned i = 0; i < NUM_PHASES; i++) begin
      if (i > cur_ph) begin
        dist = i - cur_ph;
      end else begin
        dist = i + NUM_PHASES - cur_ph;
      end
      if (pending_q[i] && (dist < best)) begin
        best       = dist;
        next_phase = PhW'(i);
      end
    end
  end

  always_comb begin
    pending_d = pending_q | tl.pass_request;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if ((state_d == StGreen) && (state_q != StGreen) && (PhW'(i) == phase_d)) begin
        pending_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end
`else
  always_comb begin
    if (phase_q == PhW'(NUM_PHASES - 1)) begin
      next_phase = '0;
    end else begin
      next_phase = phase_q + PhW'(1);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        state_d = StGreen;
        phase_d = '0;
        cnt_d   = CNT_W'(GREEN_T);
      end
      StGreen: begin
        if (cnt_last) begin
          state_d = StYellow;
          cnt_d   = CNT_W'(YELLOW_T);
        end else if (other_req && (cnt_q > CNT_W'(PASS_T))) begin
          cnt_d = CNT_W'(PASS_T);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StYellow: begin
        if (cnt_last) begin
          state_d = StAllRed;
          cnt_d   = CNT_W'(ALLRED_T);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StAllRed: begin
        if (cnt_last) begin
          state_d = StGreen;
          phase_d = next_phase;
          cnt_d   = CNT_W'(GREEN_T);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        phase_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Lamps are decoded from the next state so the registered drives line up with state_q.
  always_comb begin
    red_d    = '0;
    yellow_d = '0;
    green_d  = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if ((state_d == StGreen) && (PhW'(i) == phase_d)) begin
        green_d[i] = 1'b1;
      end else if ((state_d == StYellow) && (PhW'(i) == phase_d)) begin
        yellow_d[i] = 1'b1;
      end else begin
        red_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      phase_q  <= '0;
      cnt_q    <= '0;
      red_q    <= '1;
      yellow_q <= '0;
      green_q  <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      red_q    <= red_d;
      yellow_q <= yellow_d;
      green_q  <= green_d;
    end
  end

  assign tl.clock  = cnt_q;
  assign tl.phase  = phase_q;
  assign tl.red    = red_q;
  assign tl.yellow = yellow_q;
  assign tl.green  = green_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed, table-driven bench for traffic_light_ctrl; builds with or without
// TL_DEMAND_SKIP_EN (three phases when the macro is defined).
module tb_traffic_light_ctrl;
`ifdef TL_DEMAND_SKIP_EN
  localparam int unsigned N = 3;
`else
  localparam int unsigned N = 2;
`endif
  localparam int unsigned CW  = 8;
  localparam int unsigned PhW = ($clog2(N) > 1) ? $clog2(N) : 1;

  localparam int unsigned SI = 0;  // idle / reset
  localparam int unsigned SG = 1;
  localparam int unsigned SY = 2;
  localparam int unsigned SA = 3;  // all red

  typedef struct {
    int unsigned  adv;
    logic [N-1:0] req;
    int unsigned  st;
    int unsigned  ph;
    int unsigned  clk;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  vec_t tbl[$];

  traffic_light_if #(.NUM_PHASES(N), .CNT_W(CW)) tl ();

  traffic_light_ctrl #(
    .NUM_PHASES(N),
    .CNT_W     (CW),
    .GREEN_T   (60),
    .YELLOW_T  (5),
    .ALLRED_T  (2),
    .PASS_T    (10)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .tl   (tl)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input int unsigned st, input int unsigned ph,
                           input int unsigned cv);
    logic [N-1:0] r, y, g;
    r = '0;
    y = '0;
    g = '0;
    for (int i = 0; i < N; i++) begin
      if (st == SG && i == int'(ph))      g[i] = 1'b1;
      else if (st == SY && i == int'(ph)) y[i] = 1'b1;
      else                                r[i] = 1'b1;
    end
    check({name, ".clock"}, 64'(tl.clock), 64'(cv));
    check({name, ".phase"}, 64'(tl.phase), 64'(ph));
    check({name, ".lamps"}, 64'({tl.red, tl.yellow, tl.green}), 64'({r, y, g}));
  endtask

  // Request is driven for the first of the adv edges only; called and returns on a negedge.
  task automatic run_tbl(input string tag);
    foreach (tbl[k]) begin
      for (int i = 0; i < int'(tbl[k].adv); i++) begin
        tl.pass_request = (i == 0) ? tbl[k].req : '0;
        @(negedge clk);
      end
      tl.pass_request = '0;
      check_out($sformatf("%s%0d", tag, k), tbl[k].st, tbl[k].ph, tbl[k].clk);
    end
    tbl.delete();
  endtask

  task automatic add(input int unsigned adv, input logic [N-1:0] req, input int unsigned st,
                     input int unsigned ph, input int unsigned cv);
    tbl.push_back('{adv: adv, req: req, st: st, ph: ph, clk: cv});
  endtask

  // Every cycle: one lamp per phase, and at most one phase away from red.
  always @(negedge clk) begin
    int bad;
    int nonred;
    bad    = 0;
    nonred = 0;
    for (int i = 0; i < N; i++) begin
      if ($countones({tl.red[i], tl.yellow[i], tl.green[i]}) != 1) bad++;
      if (tl.red[i] !== 1'b1) nonred++;
    end
    checks++;
    if (bad != 0 || nonred > 1) begin
      failures++;
      $display("FAIL lamp_onehot t=%0t actual r=%b y=%b g=%b required one lamp/phase, <=1 non-red",
               $time, tl.red, tl.yellow, tl.green);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    tl.pass_request = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_out("rst_hold", SI, 0, 0);
    rst_n = 1'b1;
    check_out("rst_release", SI, 0, 0);

`ifdef TL_DEMAND_SKIP_EN
    add(1,  3'b000, SG, 0, 60);
    add(60, 3'b000, SY, 0, 5);
    add(5,  3'b000, SA, 0, 2);
    add(2,  3'b000, SG, 0, 60);  // nothing pending: phase 0 again
    add(10, 3'b100, SG, 0, 1);   // req[2] at clock 60 also shortens
    add(1,  3'b000, SY, 0, 5);
    add(5,  3'b000, SA, 0, 2);
    add(2,  3'b000, SG, 2, 60);  // phase 1 skipped
    add(60, 3'b000, SY, 2, 5);
    add(7,  3'b000, SG, 2, 60);
    run_tbl("skip");
`else
    add(1,  2'b00, SG, 0, 60);
    add(59, 2'b00, SG, 0, 1);
    add(1,  2'b00, SY, 0, 5);
    add(4,  2'b00, SY, 0, 1);
    add(1,  2'b00, SA, 0, 2);
    add(1,  2'b00, SA, 0, 1);
    add(1,  2'b00, SG, 1, 60);
    add(20, 2'b00, SG, 1, 40);
    add(1,  2'b01, SG, 1, 10);
    add(9,  2'b00, SG, 1, 1);
    add(1,  2'b00, SY, 1, 5);
    add(2,  2'b00, SY, 1, 3);
    run_tbl("base");

    // Asynchronous reset in the middle of yellow[1].
    rst_n = 1'b0;
    #1;
    check_out("rst_async", SI, 0, 0);
    @(negedge clk);
    check_out("rst_async_hold", SI, 0, 0);
    rst_n = 1'b1;
    check_out("rst_async_rel", SI, 0, 0);
    @(negedge clk);
    check_out("rst_async_green", SG, 0, 60);

    add(19, 2'b00, SG, 0, 41);
    add(1,  2'b01, SG, 0, 40);  // own request ignored
    add(1,  2'b10, SG, 0, 10);
    add(1,  2'b10, SG, 0, 9);   // clock == PASS_T: plain decrement
    add(2,  2'b00, SG, 0, 7);
    add(1,  2'b10, SG, 0, 6);
    add(5,  2'b00, SG, 0, 1);
    add(1,  2'b00, SY, 0, 5);
    add(1,  2'b10, SY, 0, 4);   // no effect outside green
    add(3,  2'b00, SY, 0, 1);
    add(1,  2'b00, SA, 0, 2);
    add(2,  2'b00, SG, 1, 60);
    add(1,  2'b01, SG, 1, 10);
    add(10, 2'b00, SY, 1, 5);
    add(5,  2'b00, SA, 1, 2);
    add(2,  2'b00, SG, 0, 60);  // wrap 1 -> 0
    run_tbl("short");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/traffic_light_ctrl.md
TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 Parameter NUM_PHASES, default 2: number of signal groups served in turn; legal range 2..8.
REQ-002 Parameter CNT_W, default 8: width of the countdown and of the clock output.
REQ-003 Parameter GREEN_T, default 60: green duration in cycles.
REQ-004 Parameter YELLOW_T, default 5: yellow duration in cycles.
REQ-005 Parameter ALLRED_T, default 2: all-red clearance duration in cycles.
REQ-006 Parameter PASS_T, default 10: shortened green remainder on request.
REQ-007 Parameter legality: 1 <= PASS_T < GREEN_T; all durations >= 1 and < 2^CNT_W.
REQ-008 Derived width PH_W = max(1, clog2(NUM_PHASES)).
REQ-009 clk  input  1  sole clock; all state updates on its rising edge.
REQ-010 rst_n  input  1  asynchronous, active-low reset.
REQ-011 pass_request  input  NUM_PHASES  per-phase crossing request, level-sampled each cycle.
REQ-012 clock  output  CNT_W  cycles remaining in the current interval.
REQ-013 phase  output  PH_W  index of the phase currently owning green/yellow.
REQ-014 red, yellow, green  output  NUM_PHASES each  per-phase lamp drives, all registered.

Function
REQ-015 FSM states: IDLE, GREEN, YELLOW, ALLRED.
REQ-016 IDLE: lasts exactly one cycle after reset release; next state GREEN for phase 0, clock loaded with GREEN_T.
REQ-017 Interval timing: an interval of length T shows clock = T, T-1, ..., 1, one value per cycle. In the cycle where clock == 1, the next state and its duration load on the next edge.
REQ-018 Sequence: GREEN(GREEN_T) -> YELLOW(YELLOW_T) -> ALLRED(ALLRED_T) -> GREEN of the next phase.
REQ-019 Lamps: in GREEN/YELLOW, the active phase drives green/yellow only; every other phase drives red. In IDLE and ALLRED, all phases drive red.
REQ-020 Exactly one lamp per phase is 1 in every cycle.
REQ-021 Green shortening: in GREEN, if pass_request[j] = 1 for any j != phase and clock > PASS_T, the next clock is PASS_T instead of clock-1.
REQ-022 Shortening conditions: no shortening when clock <= PASS_T; no shortening by the active phase's own request; no effect outside GREEN.
REQ-023 Next phase (macro absent): (phase+1) mod NUM_PHASES; wraps from NUM_PHASES-1 to 0.
REQ-024 Countdown uses CNT_W-bit unsigned arithmetic; it never underflows because a reload occurs at 1.

Reset
REQ-025 On rst_n low (asynchronous), the block SHALL drive state IDLE, phase 0, clock 0, red all-ones, yellow and green all-zeros.
REQ-026 The reset values hold until the first rising edge after rst_n rises.
REQ-027 Reset asserted mid-interval aborts the interval immediately; no partial yellow is completed.
REQ-028 When macro TL_DEMAND_SKIP_EN is defined, reset also clears all pending bits.

Configuration
REQ-029 Macro TL_DEMAND_SKIP_EN: with the macro defined, the block keeps a NUM_PHASES-bit pending register.
- pending[i] sets on pass_request[i].
- pending[i] clears on entry to GREEN of phase i; the clear takes priority over a same-cycle set.
REQ-030 Phase selection with TL_DEMAND_SKIP_EN defined: at ALLRED end, the next phase is the first pending index searched round-robin from phase+1.
- If no bit is pending, the current phase is served again.
- Shortening (REQ-021) is unchanged.
REQ-031 Without TL_DEMAND_SKIP_EN: no pending register exists and selection is strictly per REQ-023.

Verification (defaults unless stated)
REQ-032 Release reset, no requests -> 1 IDLE cycle; green[0] for 60 cycles (clock 60..1); yellow[0] for 5 cycles; all red for 2 cycles; then green[1] with clock=60.
REQ-033 pass_request[1]=1 pulse while phase 0 green at clock=40 -> next clock=10, then 9..1, then yellow[0].
REQ-034 pass_request[1]=1 at clock=7 in green, and pass_request[0]=1 at clock=40 in phase-0 green -> countdown unaffected in both cases.
REQ-035 rst_n low during yellow[1] at clock=3 -> same cycle: red=all-ones, clock=0, phase=0; after release, IDLE then green[0].
REQ-036 TL_DEMAND_SKIP_EN, NUM_PHASES=3:
- Only pass_request[2] pulsed during phase 0 -> after ALLRED, phase=2 (phase 1 skipped).
- No requests at all -> phase 0 re-served.
REQ-037 All runs -> per-phase one-hot lamp check (REQ-020) and no two phases non-red simultaneously, checked every cycle.
